// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe turn sequencer: AI (X) settle/commit, human (O) handshake, win/draw detection
module ttt_game_ctrl #(
    parameter int AI_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    input  logic [8:0] ai_move,
    output logic [8:0] x_state,
    output logic [8:0] o_state,
    output logic       illegal,
    output logic       ai_fallback,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {S_IDLE, S_AI_WAIT, S_CHECK_X, S_HUMAN, S_CHECK_O, S_DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(AI_WAIT - 1);

    function automatic logic has_line(input logic [8:0] b);
        return (&b[8:6]) | (&b[5:3]) | (&b[2:0]) |
               (b[8] & b[5] & b[2]) | (b[7] & b[4] & b[1]) | (b[6] & b[3] & b[0]) |
               (b[8] & b[4] & b[0]) | (b[6] & b[4] & b[2]);
    endfunction

    state_t     state, state_n;
    logic [8:0] x_n, o_n;
    logic [3:0] move_cnt, cnt_n;
    logic [3:0] wait_cnt, wait_n;
    logic       illegal_n, fb_n;
    logic [1:0] winner_n;

    logic [8:0] occupied, fb_bit, human_cell;
    logic       ai_usable, human_legal;

    assign occupied    = x_state | o_state;
    assign ai_usable   = (ai_move != 9'd0) && ((ai_move & (ai_move - 9'd1)) == 9'd0) &&
                         ((ai_move & occupied) == 9'd0);
    assign human_cell  = 9'h100 >> move_pos;
    assign human_legal = (move_pos <= 4'd8) && ((human_cell & occupied) == 9'd0);

    // Highest empty bit wins because later iterations overwrite earlier ones.
    always_comb begin
        fb_bit = 9'd0;
        for (int i = 0; i < 9; i++) begin
            if (!occupied[i]) fb_bit = 9'd1 << i;
        end
    end

    always_comb begin
        state_n   = state;
        x_n       = x_state;
        o_n       = o_state;
        cnt_n     = move_cnt;
        wait_n    = wait_cnt;
        winner_n  = winner;
        illegal_n = 1'b0;
        fb_n      = 1'b0;
        if (start) begin
            x_n      = 9'd0;
            o_n      = 9'd0;
            cnt_n    = 4'd0;
            wait_n   = WAIT_LOAD;
            winner_n = 2'b00;
            state_n  = S_AI_WAIT;
        end else begin
            case (state)
                S_AI_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        x_n     = x_state | (ai_usable ? ai_move : fb_bit);
                        fb_n    = !ai_usable;
                        cnt_n   = move_cnt + 4'd1;
                        state_n = S_CHECK_X;
                    end else begin
                        wait_n = wait_cnt - 4'd1;
                    end
                end
                S_CHECK_X: begin
                    if (has_line(x_state)) begin
                        winner_n = 2'b01;
                        state_n  = S_DONE;
                    end else if (move_cnt == 4'd9) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_HUMAN;
                    end
                end
                S_HUMAN: begin
                    if (move_valid) begin
                        if (human_legal) begin
                            o_n     = o_state | human_cell;
                            cnt_n   = move_cnt + 4'd1;
                            state_n = S_CHECK_O;
                        end else begin
                            illegal_n = 1'b1;
                        end
                    end
                end
                S_CHECK_O: begin
                    if (has_line(o_state)) begin
                        winner_n = 2'b10;
                        state_n  = S_DONE;
                    end else if (move_cnt == 4'd9) begin
                        state_n = S_DONE;
                    end else begin
                        wait_n  = WAIT_LOAD;
                        state_n = S_AI_WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            x_state     <= 9'd0;
            o_state     <= 9'd0;
            move_cnt    <= 4'd0;
            wait_cnt    <= 4'd0;
            winner      <= 2'b00;
            illegal     <= 1'b0;
            ai_fallback <= 1'b0;
        end else begin
            state       <= state_n;
            x_state     <= x_n;
            o_state     <= o_n;
            move_cnt    <= cnt_n;
            wait_cnt    <= wait_n;
            winner      <= winner_n;
            illegal     <= illegal_n;
            ai_fallback <= fb_n;
        end
    end

    assign move_ready = (state == S_HUMAN);
    assign game_over  = (state == S_DONE);

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - self-checking bench for ttt_game_ctrl
module tb_ttt_game_ctrl;

    localparam int AIW = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos = 4'd0;
    logic       move_ready;
    logic [8:0] ai_move = 9'd0;
    logic [8:0] x_state, o_state;
    logic       illegal, ai_fallback, game_over;
    logic [1:0] winner;

    ttt_game_ctrl #(.AI_WAIT(AIW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid),
        .move_pos(move_pos), .move_ready(move_ready), .ai_move(ai_move),
        .x_state(x_state), .o_state(o_state), .illegal(illegal),
        .ai_fallback(ai_fallback), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         s;
        bit         mv;
        logic [3:0] p;
        logic [8:0] ai;
        logic [8:0] ex;
        logic [8:0] eo;
        bit         rdy;
        bit         ill;
        bit         fb;
        bit         go;
        logic [1:0] w;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference board: one entry per cell position (0 top-left, row-major); 0 empty, 1 X, 2 O.
    int mb[9];
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit s, input bit mv, input logic [3:0] p, input logic [8:0] ai,
                       input logic [8:0] ex, input logic [8:0] eo, input bit rdy, input bit ill,
                       input bit fb, input bit go, input logic [1:0] w);
        vec_t v;
        v.s = s; v.mv = mv; v.p = p; v.ai = ai; v.ex = ex; v.eo = eo;
        v.rdy = rdy; v.ill = ill; v.fb = fb; v.go = go; v.w = w;
        vecs.push_back(v);
    endtask

    task automatic wait_turn(output int fbs);
        fbs = 0;
        for (int i = 0; i < 60; i++) begin
            if (move_ready || game_over) break;
            step();
            if (ai_fallback) fbs++;
        end
        if (!(move_ready || game_over)) chk("turn_timeout", 32'd0, 32'd1);
    endtask

    function automatic bit model_line(int who);
        for (int l = 0; l < 8; l++)
            if (mb[lines[l][0]] == who && mb[lines[l][1]] == who && mb[lines[l][2]] == who) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [8:0] model_bits(int who);
        logic [8:0] r = 9'd0;
        for (int p = 0; p < 9; p++) r[8-p] = (mb[p] == who);
        return r;
    endfunction

    function automatic int model_ai(logic [8:0] a, output bit fb);
        int ones = 0;
        int p = 0;
        for (int k = 0; k < 9; k++) if (a[k]) begin ones++; p = 8 - k; end
        fb = 1'b0;
        if (ones == 1 && mb[p] == 0) return p;
        fb = 1'b1;
        for (int q = 0; q < 9; q++) if (mb[q] == 0) return q;
        return 0;
    endfunction

    function automatic logic [8:0] rand_ai();
        int r = $urandom_range(0, 9);
        int b1 = $urandom_range(0, 8);
        int b2 = (b1 + 1 + $urandom_range(0, 7)) % 9;
        if (r < 6) return 9'd1 << b1;
        if (r < 7) return 9'd0;
        if (r < 9) return (9'd1 << b1) | (9'd1 << b2);
        return 9'($urandom);
    endfunction

    task automatic human(input logic [3:0] p);
        move_valid = 1'b1;
        move_pos   = p;
        step();
        move_valid = 1'b0;
    endtask

    int         fbs, nm, pos, tries, wexp;
    bit         efb, over, legal;
    logic [8:0] before_o;

    initial begin
        // Reset state
        step();
        step();
        chk("rst_x", 32'(x_state), 32'd0);
        chk("rst_o", 32'(o_state), 32'd0);
        chk("rst_rdy", 32'(move_ready), 32'd0);
        chk("rst_go", 32'(game_over), 32'd0);
        chk("rst_win", 32'(winner), 32'd0);
        rst_n = 1'b1;
        move_valid = 1'b1;
        step();
        step();
        move_valid = 1'b0;
        chk("idle_x", 32'(x_state), 32'd0);
        chk("idle_rdy", 32'(move_ready), 32'd0);
        chk("idle_ill", 32'(illegal), 32'd0);

        // Opening, illegal moves, AI win
        add(1,0,0,9'b100000000, 9'b000000000,9'b000000000, 0,0,0,0,2'b00);
        add(0,0,0,9'b100000000, 9'b000000000,9'b000000000, 0,0,0,0,2'b00);
        add(0,0,0,9'b100000000, 9'b100000000,9'b000000000, 0,0,0,0,2'b00);
        add(0,0,0,9'b100000000, 9'b100000000,9'b000000000, 1,0,0,0,2'b00);
        add(0,1,0,9'b100000000, 9'b100000000,9'b000000000, 1,1,0,0,2'b00);
        add(0,1,9,9'b100000000, 9'b100000000,9'b000000000, 1,1,0,0,2'b00);
        add(0,0,0,9'b100000000, 9'b100000000,9'b000000000, 1,0,0,0,2'b00);
        add(0,1,4,9'b010000000, 9'b100000000,9'b000010000, 0,0,0,0,2'b00);
        add(0,0,0,9'b010000000, 9'b100000000,9'b000010000, 0,0,0,0,2'b00);
        add(0,0,0,9'b010000000, 9'b100000000,9'b000010000, 0,0,0,0,2'b00);
        add(0,0,0,9'b010000000, 9'b110000000,9'b000010000, 0,0,0,0,2'b00);
        add(0,0,0,9'b010000000, 9'b110000000,9'b000010000, 1,0,0,0,2'b00);
        add(0,1,8,9'b001000000, 9'b110000000,9'b000010001, 0,0,0,0,2'b00);
        add(0,0,0,9'b001000000, 9'b110000000,9'b000010001, 0,0,0,0,2'b00);
        add(0,0,0,9'b001000000, 9'b110000000,9'b000010001, 0,0,0,0,2'b00);
        add(0,0,0,9'b001000000, 9'b111000000,9'b000010001, 0,0,0,0,2'b00);
        add(0,0,0,9'b001000000, 9'b111000000,9'b000010001, 0,0,0,1,2'b01);
        add(0,1,5,9'b001000000, 9'b111000000,9'b000010001, 0,0,0,1,2'b01);
        // Unusable AI output: zero, two-hot, occupied one-hot
        add(1,0,0,9'b000000000, 9'b000000000,9'b000000000, 0,0,0,0,2'b00);
        add(0,0,0,9'b000000000, 9'b000000000,9'b000000000, 0,0,0,0,2'b00);
        add(0,0,0,9'b000000000, 9'b100000000,9'b000000000, 0,0,1,0,2'b00);
        add(0,0,0,9'b000000000, 9'b100000000,9'b000000000, 1,0,0,0,2'b00);
        add(0,1,1,9'b000000011, 9'b100000000,9'b010000000, 0,0,0,0,2'b00);
        add(0,0,0,9'b000000011, 9'b100000000,9'b010000000, 0,0,0,0,2'b00);
        add(0,0,0,9'b000000011, 9'b100000000,9'b010000000, 0,0,0,0,2'b00);
        add(0,0,0,9'b000000011, 9'b101000000,9'b010000000, 0,0,1,0,2'b00);
        add(0,0,0,9'b000000011, 9'b101000000,9'b010000000, 1,0,0,0,2'b00);
        add(0,1,8,9'b100000000, 9'b101000000,9'b010000001, 0,0,0,0,2'b00);
        add(0,0,0,9'b100000000, 9'b101000000,9'b010000001, 0,0,0,0,2'b00);
        add(0,0,0,9'b100000000, 9'b101000000,9'b010000001, 0,0,0,0,2'b00);
        add(0,0,0,9'b100000000, 9'b101100000,9'b010000001, 0,0,1,0,2'b00);
        add(0,0,0,9'b100000000, 9'b101100000,9'b010000001, 1,0,0,0,2'b00);
        // start beats a coincident human handshake
        add(1,1,4,9'b000100000, 9'b000000000,9'b000000000, 0,0,0,0,2'b00);
        add(0,0,0,9'b000100000, 9'b000000000,9'b000000000, 0,0,0,0,2'b00);
        add(0,0,0,9'b000100000, 9'b000100000,9'b000000000, 0,0,0,0,2'b00);
        add(0,0,0,9'b000100000, 9'b000100000,9'b000000000, 1,0,0,0,2'b00);

        foreach (vecs[i]) begin
            start = vecs[i].s; move_valid = vecs[i].mv; move_pos = vecs[i].p; ai_move = vecs[i].ai;
            step();
            chk($sformatf("v%0d_x", i), 32'(x_state), 32'(vecs[i].ex));
            chk($sformatf("v%0d_o", i), 32'(o_state), 32'(vecs[i].eo));
            chk($sformatf("v%0d_rdy", i), 32'(move_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_ill", i), 32'(illegal), 32'(vecs[i].ill));
            chk($sformatf("v%0d_fb", i), 32'(ai_fallback), 32'(vecs[i].fb));
            chk($sformatf("v%0d_go", i), 32'(game_over), 32'(vecs[i].go));
            chk($sformatf("v%0d_win", i), 32'(winner), 32'(vecs[i].w));
        end
        start = 1'b0; move_valid = 1'b0;

        // Scripted draw: X 0,2,3,7,8 / O 1,4,5,6
        ai_move = 9'h100 >> 0;
        start = 1'b1; step(); start = 1'b0;
        wait_turn(fbs);
        human(4'd1); ai_move = 9'h100 >> 2; wait_turn(fbs);
        human(4'd4); ai_move = 9'h100 >> 3; wait_turn(fbs);
        human(4'd5); ai_move = 9'h100 >> 7; wait_turn(fbs);
        human(4'd6); ai_move = 9'h100 >> 8; wait_turn(fbs);
        chk("draw_x", 32'(x_state), 32'(9'b101100011));
        chk("draw_o", 32'(o_state), 32'(9'b010011100));
        chk("draw_go", 32'(game_over), 32'd1);
        chk("draw_win", 32'(winner), 32'd0);
        step();
        chk("draw_hold_go", 32'(game_over), 32'd1);
        start = 1'b1; step(); start = 1'b0;
        chk("restart_x", 32'(x_state), 32'd0);
        chk("restart_o", 32'(o_state), 32'd0);
        chk("restart_go", 32'(game_over), 32'd0);

        // Randomised games against the rule-level model
        for (int g = 0; g < 40; g++) begin
            ai_move = rand_ai();
            start = 1'b1; step(); start = 1'b0;
            for (int c = 0; c < 9; c++) mb[c] = 0;
            nm = 0; over = 1'b0; wexp = 0;
            while (!over) begin
                pos = model_ai(ai_move, efb);
                mb[pos] = 1; nm++;
                if (model_line(1)) begin over = 1'b1; wexp = 1; end
                else if (nm == 9) over = 1'b1;
                wait_turn(fbs);
                chk("rnd_ai_x", 32'(x_state), 32'(model_bits(1)));
                chk("rnd_ai_o", 32'(o_state), 32'(model_bits(2)));
                chk("rnd_ai_fb", 32'(fbs), 32'(efb));
                chk("rnd_ai_go", 32'(game_over), 32'(over));
                if (over) begin
                    chk("rnd_ai_win", 32'(winner), 32'(wexp));
                    break;
                end
                tries = 0;
                legal = 1'b0;
                while (!legal) begin
                    if (tries < 2) pos = $urandom_range(0, 10);
                    else for (int q = 8; q >= 0; q--) if (mb[q] == 0) pos = q;
                    tries++;
                    legal = (pos <= 8) && (mb[pos] == 0);
                    before_o = o_state;
                    ai_move = rand_ai();
                    human(4'(pos));
                    chk("rnd_h_ill", 32'(illegal), 32'(!legal));
                    chk("rnd_h_rdy", 32'(move_ready), 32'(!legal));
                    if (legal) mb[pos] = 2;
                    chk("rnd_h_o", 32'(o_state), 32'(model_bits(2)));
                    if (tries > 6) break;
                end
                nm++;
                if (model_line(2)) begin
                    over = 1'b1;
                    wait_turn(fbs);
                    chk("rnd_o_go", 32'(game_over), 32'd1);
                    chk("rnd_o_win", 32'(winner), 32'd2);
                    chk("rnd_o_x", 32'(x_state), 32'(model_bits(1)));
                end
            end
        end

        // Asynchronous reset mid-game
        ai_move = 9'b000010000;
        start = 1'b1; step(); start = 1'b0;
        wait_turn(fbs);
        chk("pre_rst_rdy", 32'(move_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_x", 32'(x_state), 32'd0);
        chk("arst_o", 32'(o_state), 32'd0);
        chk("arst_rdy", 32'(move_ready), 32'd0);
        chk("arst_ill", 32'(illegal), 32'd0);
        chk("arst_fb", 32'(ai_fallback), 32'd0);
        chk("arst_go", 32'(game_over), 32'd0);
        chk("arst_win", 32'(winner), 32'd0);
        step();
        rst_n = 1'b1;
        move_valid = 1'b1; move_pos = 4'd3;
        for (int i = 0; i < AIW + 3; i++) step();
        move_valid = 1'b0;
        chk("post_rst_x", 32'(x_state), 32'd0);
        chk("post_rst_o", 32'(o_state), 32'd0);
        chk("post_rst_rdy", 32'(move_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
